// File: rtl/note_detector.sv
// note_detector: classifies the period of a square-wave tone into one of
// three expected note periods, with candidate confirmation and silence timeout.
`timescale 1ns/1ps

`ifndef DO_4
`define DO_4 191113
`endif
`ifndef RE_4
`define RE_4 170265
`endif
`ifndef MI_4
`define MI_4 151686
`endif
`ifndef T_1s
`define T_1s 50000000
`endif

module note_detector #(
    parameter int N0      = `DO_4,
    parameter int N1      = `RE_4,
    parameter int N2      = `MI_4,
    parameter int TOL     = 64,
    parameter int CONFIRM = 4,
    parameter int TIMEOUT = `T_1s/8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ch_in,
    output logic [1:0] note,
    output logic       valid,
    output logic       note_chg
);

    typedef enum logic {SILENT = 1'b0, TRACK = 1'b1} state_t;

    localparam logic [24:0] L_N0      = 25'(N0);
    localparam logic [24:0] L_N1      = 25'(N1);
    localparam logic [24:0] L_N2      = 25'(N2);
    localparam logic [24:0] L_TOL     = 25'(TOL);
    localparam logic [3:0]  L_CONFIRM = 4'(CONFIRM);
    localparam logic [23:0] L_TMO     = 24'(TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic        r_sync1, r_sync2, r_sync3;
    logic        w_rise;
    logic [23:0] r_cnt;
    logic [24:0] w_per;
    logic [1:0]  r_note, w_note_nxt;
    logic [1:0]  r_cand, w_cand_nxt;
    logic [1:0]  w_class;
    logic [3:0]  r_mcnt, w_mcnt_nxt;
    logic        r_note_chg;

    // 25-bit operands so the distance never wraps
    function automatic logic near(input logic [24:0] p, input logic [24:0] n);
        logic [24:0] d;
        d = (p >= n) ? (p - n) : (n - p);
        return d <= L_TOL;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= ch_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_rise = r_sync2 & ~r_sync3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 24'd0;
        end else if (w_rise) begin
            r_cnt <= 24'd0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 24'd1;
        end
    end

    assign w_per = {1'b0, r_cnt} + 25'd1;

    always_comb begin
        w_class = 2'd3;
        if (near(w_per, L_N0)) begin
            w_class = 2'd0;
        end else if (near(w_per, L_N1)) begin
            w_class = 2'd1;
        end else if (near(w_per, L_N2)) begin
            w_class = 2'd2;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_note_nxt  = r_note;
        w_cand_nxt  = r_cand;
        w_mcnt_nxt  = r_mcnt;
        case (r_state)
            SILENT: begin
                if (w_rise) begin
                    w_state_nxt = TRACK;
                end
            end
            TRACK: begin
                // a rise on the timeout cycle is still classified
                if (w_rise) begin
                    if (w_class == r_cand) begin
                        if (r_mcnt < L_CONFIRM) begin
                            w_mcnt_nxt = r_mcnt + 4'd1;
                        end
                    end else begin
                        w_cand_nxt = w_class;
                        w_mcnt_nxt = 4'd1;
                    end
                    if (w_mcnt_nxt == L_CONFIRM && w_cand_nxt != r_note) begin
                        w_note_nxt = w_cand_nxt;
                    end
                end else if (r_cnt == L_TMO) begin
                    w_state_nxt = SILENT;
                    w_note_nxt  = 2'd3;
                    w_cand_nxt  = 2'd3;
                    w_mcnt_nxt  = 4'd0;
                end
            end
            default: begin
                w_state_nxt = SILENT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= SILENT;
            r_note     <= 2'd3;
            r_cand     <= 2'd3;
            r_mcnt     <= 4'd0;
            r_note_chg <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_note     <= w_note_nxt;
            r_cand     <= w_cand_nxt;
            r_mcnt     <= w_mcnt_nxt;
            r_note_chg <= (w_note_nxt != r_note);
        end
    end

    assign note     = r_note;
    assign valid    = (r_note != 2'd3);
    assign note_chg = r_note_chg;

endmodule

// File: tb/tb_note_detector.sv
// tb_note_detector: directed and randomized tone stimulus checked every cycle
// against a timestamp-based reference model of the note classifier.
`timescale 1ns/1ps

module tb_note_detector;

    localparam int N0      = 100;
    localparam int N1      = 80;
    localparam int N2      = 60;
    localparam int TOL     = 4;
    localparam int CONFIRM = 2;
    localparam int TIMEOUT = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ch_in = 1'b0;
    logic [1:0] note;
    logic       valid;
    logic       note_chg;

    int n_chk = 0;
    int n_fail = 0;
    int n_pulse = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    // input rising-edge timestamps (edge index after which ch_in went high)
    int rq[$];

    int m_note = 3;
    int m_cand = 3;
    int m_mcnt = 0;
    int m_last = 0;
    bit m_trk = 1'b0;
    bit m_chg = 1'b0;

    note_detector #(
        .N0(N0), .N1(N1), .N2(N2),
        .TOL(TOL), .CONFIRM(CONFIRM), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ch_in(ch_in),
        .note(note),
        .valid(valid),
        .note_chg(note_chg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input int p);
        int n[3];
        n[0] = N0;
        n[1] = N1;
        n[2] = N2;
        for (int i = 0; i < 3; i++) begin
            if (((p > n[i]) ? (p - n[i]) : (n[i] - p)) <= TOL) return i;
        end
        return 3;
    endfunction

    // Reference model: an input edge after edge c is acted on at edge c+3;
    // periods and timeouts come from differences of those edge indices.
    initial begin
        int e;
        int prev;
        int p;
        int cls;
        bit rise_now;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_note = 3;
                m_cand = 3;
                m_mcnt = 0;
                m_trk  = 1'b0;
                m_chg  = 1'b0;
                rq.delete();
            end else begin
                e = cyc + 1;
                prev = m_note;
                rise_now = (rq.size() > 0) && (rq[0] == e - 3);
                if (rise_now) void'(rq.pop_front());
                if (!m_trk) begin
                    if (rise_now) begin
                        m_trk = 1'b1;
                        m_last = e;
                    end
                end else if (rise_now) begin
                    p = e - m_last;
                    m_last = e;
                    cls = classify(p);
                    if (cls == m_cand) begin
                        if (m_mcnt < CONFIRM) m_mcnt++;
                    end else begin
                        m_cand = cls;
                        m_mcnt = 1;
                    end
                    if (m_mcnt == CONFIRM && m_cand != m_note) m_note = m_cand;
                end else if (e - m_last == TIMEOUT) begin
                    m_trk  = 1'b0;
                    m_note = 3;
                    m_cand = 3;
                    m_mcnt = 0;
                end
                m_chg = (m_note != prev);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("note", int'(note), m_note);
                chk("valid", int'(valid), int'(m_note != 3));
                chk("note_chg", int'(note_chg), int'(m_chg));
                if (note_chg) n_pulse++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tone(input int p, input int n);
        for (int k = 0; k < n; k++) begin
            ch_in = 1'b1;
            rq.push_back(cyc);
            step(p / 2);
            ch_in = 1'b0;
            step(p - p / 2);
        end
    endtask

    task automatic do_reset();
        ch_in = 1'b0;
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(2);
    endtask

    initial begin
        int sel;
        int p;
        @(posedge clk);
        #1;
        step(3);
        chk("rst_note", int'(note), 3);
        chk("rst_valid", int'(valid), 0);
        chk("rst_chg", int'(note_chg), 0);
        mon_en = 1'b1;
        rst = 1'b0;
        n_pulse = 0;
        step(5);
        chk("release_pulse", n_pulse, 0);

        tone(100, 3);
        chk("lock100_note", int'(note), 0);
        chk("lock100_valid", int'(valid), 1);
        chk("lock100_pulses", n_pulse, 1);

        n_pulse = 0;
        tone(60, 2);
        chk("mixed_hold_note", int'(note), 0);
        tone(60, 1);
        chk("lock60_note", int'(note), 2);
        chk("lock60_pulses", n_pulse, 1);

        tone(103, 4);
        chk("p103_note", int'(note), 0);
        tone(105, 4);
        chk("p105_note", int'(note), 3);
        chk("p105_valid", int'(valid), 0);

        do_reset();
        n_pulse = 0;
        for (int k = 0; k < 6; k++) begin
            tone(100, 1);
            tone(80, 1);
        end
        chk("alt_note", int'(note), 3);
        chk("alt_pulses", n_pulse, 0);

        tone(100, 4);
        chk("relock_note", int'(note), 0);
        n_pulse = 0;
        step(150);
        chk("pre_timeout_note", int'(note), 0);
        step(80);
        chk("timeout_note", int'(note), 3);
        chk("timeout_pulses", n_pulse, 1);
        tone(80, 3);
        chk("after_silence_note", int'(note), 1);

        n_pulse = 0;
        tone(300, 2);
        chk("edge299_no_timeout", int'(note), 1);
        tone(300, 1);
        chk("p300_class3_note", int'(note), 3);
        chk("p300_pulses", n_pulse, 1);

        tone(100, 4);
        chk("prereset_note", int'(note), 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_note", int'(note), 3);
        chk("async_rst_valid", int'(valid), 0);
        chk("async_rst_chg", int'(note_chg), 0);
        step(3);
        rst = 1'b0;
        n_pulse = 0;
        step(20);
        chk("async_rel_pulses", n_pulse, 0);
        chk("async_rel_note", int'(note), 3);

        for (int s = 0; s < 120; s++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1: p = N0;
                2, 3: p = N1;
                4: p = N2;
                5: p = N0 - TOL - 1 + int'($urandom_range(0, 2 * TOL + 2));
                6: p = N1 - TOL - 1 + int'($urandom_range(0, 2 * TOL + 2));
                7: p = N2 - TOL - 1 + int'($urandom_range(0, 2 * TOL + 2));
                8: p = int'($urandom_range(40, 320));
                default: p = 0;
            endcase
            if (p == 0) begin
                step(int'($urandom_range(50, 400)));
            end else begin
                tone(p, int'($urandom_range(1, 4)));
            end
        end
        step(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
